hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding unit for the 5-stage pipeline. It generates E-stage and D-stage forwarding selects, load-use and branch-operand stalls, and tracks a multi-cycle multiply/divide unit with an internal busy countdown. It sits beside the datapath and drives the F/D pipeline-register enables, the D/E flush, and the operand muxes in D and E. An optional saturating stall counter supports performance measurement.

---
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects, load-use / branch / mult-div stalls,
// and the mult/div busy countdown for the 5-stage pipeline.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall counter.

// One operand lane: E-stage 2-bit select and D-stage 1-bit select.
module hazard_fwd_lane #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_E,
  input  logic [AW-1:0] src_D,
  input  logic          regwrite_M,
  input  logic          memtoreg_M,
  input  logic [AW-1:0] writereg_M,
  input  logic          regwrite_W,
  input  logic [AW-1:0] writereg_W,
  output logic [1:0]    fwd_E,
  output logic          fwd_D
);
  // M result has priority over W; register 0 never forwards
  always_comb begin
    fwd_E = 2'b00;
    if ((src_E != '0) && (src_E == writereg_M) && regwrite_M)      fwd_E = 2'b10;
    else if ((src_E != '0) && (src_E == writereg_W) && regwrite_W) fwd_E = 2'b01;
  end

  // Only an ALU result is available in M; a load's data is not yet back
  always_comb begin
    fwd_D = (src_D != '0) && (src_D == writereg_M) && regwrite_M && !memtoreg_M;
  end
endmodule

module hazard_scoreboard #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs_D,
  input  logic [AW-1:0]    rt_D,
  input  logic             branch_D,
  input  logic             md_start_D,
  input  logic             mfhilo_D,
  input  logic [AW-1:0]    rs_E,
  input  logic [AW-1:0]    rt_E,
  input  logic             regwrite_E,
  input  logic             memtoreg_E,
  input  logic [AW-1:0]    writereg_E,
  input  logic             regwrite_M,
  input  logic             memtoreg_M,
  input  logic [AW-1:0]    writereg_M,
  input  logic             regwrite_W,
  input  logic [AW-1:0]    writereg_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             fwd_a_D,
  output logic             fwd_b_D,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_E,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NUM_OPS = 2;
  localparam int MDW     = $clog2(MD_LAT + 1);

  typedef enum logic {IDLE, BUSY} md_state_e;

  // Operand lanes: index 0 = rs/a, index 1 = rt/b
  logic [NUM_OPS-1:0][AW-1:0] src_E, src_D;
  logic [NUM_OPS-1:0][1:0]    fwd_E;
  logic [NUM_OPS-1:0]         fwd_D;

  assign src_E = {rt_E, rs_E};
  assign src_D = {rt_D, rs_D};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_lane
    hazard_fwd_lane #(.AW(AW)) u_lane (
      .src_E      (src_E[i]),
      .src_D      (src_D[i]),
      .regwrite_M (regwrite_M),
      .memtoreg_M (memtoreg_M),
      .writereg_M (writereg_M),
      .regwrite_W (regwrite_W),
      .writereg_W (writereg_W),
      .fwd_E      (fwd_E[i]),
      .fwd_D      (fwd_D[i])
    );
  end

  assign fwd_a_E = fwd_E[0];
  assign fwd_b_E = fwd_E[1];
  assign fwd_a_D = fwd_D[0];
  assign fwd_b_D = fwd_D[1];

  logic [MDW-1:0] md_cnt_q, md_cnt_d;
  md_state_e      md_state;
  logic           dep_rs_E, dep_rt_E, dep_rs_M, dep_rt_M;
  logic           lw_stall, br_stall, md_stall, stall;

  // State is a view of the countdown: nonzero means a mult/div is in flight
  always_comb begin
    md_state = (md_cnt_q != '0) ? BUSY : IDLE;
    md_busy  = (md_state == BUSY);
  end

  // Hazard detection; all three stall outputs are one signal
  always_comb begin
    dep_rs_E = (rs_D != '0) && (rs_D == writereg_E);
    dep_rt_E = (rt_D != '0) && (rt_D == writereg_E);
    dep_rs_M = (rs_D != '0) && (rs_D == writereg_M);
    dep_rt_M = (rt_D != '0) && (rt_D == writereg_M);
    lw_stall = memtoreg_E && regwrite_E && (dep_rs_E || dep_rt_E);
    br_stall = branch_D && ((regwrite_E && (dep_rs_E || dep_rt_E)) ||
                            (memtoreg_M && (dep_rs_M || dep_rt_M)));
    md_stall = md_busy && (md_start_D || mfhilo_D);
    stall    = lw_stall || br_stall || md_stall;
    stall_F  = stall;
    stall_D  = stall;
    flush_E  = stall;
  end

  // Countdown next state: a start is accepted only when not stalled, which
  // also holds a back-to-back start until the first idle cycle
  always_comb begin
    md_cnt_d = md_cnt_q;
    case (md_state)
      IDLE: if (md_start_D && !stall) md_cnt_d = MDW'(MD_LAT);
      BUSY: md_cnt_d = md_cnt_q - 1'b1;
      default: md_cnt_d = '0;
    endcase
  end

  // Countdown register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) md_cnt_q <= '0;
    else     md_cnt_q <= md_cnt_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (AW=5, MD_LAT=4, CNT_W=4).
// Counter expectations depend on whether HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;
  localparam int AW = 5, MD_LAT = 4, CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W;
  logic branch_D, md_start_D, mfhilo_D;
  logic regwrite_E, memtoreg_E, regwrite_M, memtoreg_M, regwrite_W;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic fwd_a_D, fwd_b_D, stall_F, stall_D, flush_E, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rt_D(rt_D), .branch_D(branch_D), .md_start_D(md_start_D),
    .mfhilo_D(mfhilo_D), .rs_E(rs_E), .rt_E(rt_E),
    .regwrite_E(regwrite_E), .memtoreg_E(memtoreg_E), .writereg_E(writereg_E),
    .regwrite_M(regwrite_M), .memtoreg_M(memtoreg_M), .writereg_M(writereg_M),
    .regwrite_W(regwrite_W), .writereg_W(writereg_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stall bundle packed as {stall_F, stall_D, flush_E}
  function automatic logic [31:0] stl();
    return {29'd0, stall_F, stall_D, flush_E};
  endfunction

  task automatic clr();
    rs_D = '0; rt_D = '0; rs_E = '0; rt_E = '0;
    writereg_E = '0; writereg_M = '0; writereg_W = '0;
    branch_D = 0; md_start_D = 0; mfhilo_D = 0;
    regwrite_E = 0; memtoreg_E = 0; regwrite_M = 0; memtoreg_M = 0; regwrite_W = 0;
  endtask

  // inputs change 2 units after a rising edge, outputs settle by +1
  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    clr();
    #1;
    chk("rst_busy", md_busy, 0);
    chk("rst_stall", stl(), 0);
    chk("rst_fwd", {fwd_a_E, fwd_b_E, fwd_a_D, fwd_b_D}, 0);
    chk("rst_cnt", stall_cnt, 0);
    tick(); rst = 0;

    // E forwarding priority
    rs_E = 3; writereg_M = 3; regwrite_M = 1; writereg_W = 3; regwrite_W = 1; #1;
    chk("fwdE_M", fwd_a_E, 2'b10);
    regwrite_M = 0; #1;
    chk("fwdE_W", fwd_a_E, 2'b01);
    rs_E = 0; #1;
    chk("fwdE_r0", fwd_a_E, 2'b00);
    rt_E = 3; #1;
    chk("fwdbE_W", fwd_b_E, 2'b01);
    clr(); tick();

    // load-use
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rt_D = 8; #1;
    chk("lw_stall", stl(), 3'b111);
    tick(); clr();
    memtoreg_M = 1; regwrite_M = 1; writereg_M = 8; rt_E = 8; rt_D = 8; #1;
    chk("lw_fwdbE", fwd_b_E, 2'b10);
    chk("lw_nostall", stl(), 0);
    chk("lw_nofwdD", fwd_b_D, 0);
    clr();
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 0; rs_D = 0; #1;
    chk("lw_r0", stl(), 0);
    clr(); tick();

    // branch dependences
    branch_D = 1; rs_D = 5; regwrite_E = 1; writereg_E = 5; #1;
    chk("br_E", stl(), 3'b111);
    tick(); regwrite_E = 0; writereg_E = 0; regwrite_M = 1; writereg_M = 5; #1;
    chk("br_fwdD", fwd_a_D, 1);
    chk("br_M_nostall", stl(), 0);
    memtoreg_M = 1; #1;
    chk("br_ldM", stl(), 3'b111);
    chk("br_ldM_nofwd", fwd_a_D, 0);
    rs_D = 0; rt_D = 5; #1;
    chk("br_rt_ldM", stl(), 3'b111);
    branch_D = 0; #1;
    chk("nobr_ldM", stl(), 0);
    clr(); tick();

    // mult/div timing, counter starts from a fresh reset
    rst = 1; #1; rst = 0;
    md_start_D = 1; #1;
    chk("md_t_busy", md_busy, 0);
    chk("md_t_stall", stl(), 0);
    tick(); md_start_D = 0; mfhilo_D = 1;
    for (int k = 1; k <= MD_LAT; k++) begin
      #1;
      chk($sformatf("md_busy_t%0d", k), md_busy, 1);
      chk($sformatf("md_stall_t%0d", k), stl(), 3'b111);
      tick();
    end
    #1;
    chk("md_t5_busy", md_busy, 0);
    chk("md_t5_stall", stl(), 0);
    chk("md_cnt4", stall_cnt, PERF ? 4 : 0);
    clr(); tick();

    // back-to-back start: second held until first idle cycle
    md_start_D = 1; tick();
    #1; chk("b2b_stall", stl(), 3'b111);
    repeat (MD_LAT) tick();
    #1; chk("b2b_idle", {md_busy, stl()}, 0);
    tick(); #1; chk("b2b_accepted", md_busy, 1);
    clr();
    rst = 1; #1; rst = 0; tick();

    // async reset mid-operation
    md_start_D = 1; tick(); md_start_D = 0; mfhilo_D = 1; tick(); #1;
    chk("ar_pre_busy", md_busy, 1);
    chk("ar_pre_cnt", stall_cnt, PERF ? 1 : 0);
    rst = 1; #1;
    chk("ar_busy", md_busy, 0);
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_stall", stl(), 0);
    #1; rst = 0; tick(); #1;
    chk("ar_after", {md_busy, stl()}, 0);
    clr();

    // saturation
    rst = 1; #1; rst = 0;
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rs_D = 8;
    repeat (5) tick();
    #1; chk("cnt5", stall_cnt, PERF ? 5 : 0);
    repeat (15) tick();
    #1; chk("cnt_sat", stall_cnt, PERF ? 15 : 0);
    clr(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
